// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and pointer helpers for the async FIFO write-side controller.
// Gray helpers work on a wide container; callers truncate to their pointer width.
package fifo_wr_sched_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 32;
    localparam int PTR_MAX_W       = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } wr_state_e;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits of a narrower pointer leave the prefix-xor unchanged.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Packet-source bundle: NREQ parallel valid/ready beat streams into the write scheduler.
// A beat on lane i transfers on a wclk edge where req_valid[i] & req_ready[i]; sources hold it until then.
interface fifo_wr_sched_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_last;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or above rr_ptr_i, wrapping modulo NREQ.
module fifo_wr_sched_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic found;

    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        // k is the distance above rr_ptr_i; smallest distance wins.
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (((i - int'(rr_ptr_i) + NREQ) % NREQ) == k)) begin
                    found     = 1'b1;
                    gnt_idx_o = IW'(i);
                end
            end
        end
        gnt_oh_o = found ? (NREQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Async FIFO write-domain controller: round-robin packet arbitration onto the single
// RAM write port, binary/Gray write pointers, and full/almost-full/level from wq2_rptr.
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
#(
    parameter  int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter  int NREQ       = 4,
    parameter  int AFULL_TH   = 12,
    localparam int PW         = ADDR_WIDTH + 1,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    fifo_wr_sched_if.slave        req_if,
    input  logic [PW-1:0]         wq2_rptr_i,
    output logic                  mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [PW-1:0]         wptr_o,
    output logic                  wfull_o,
    output logic                  wafull_o,
    output logic [PW-1:0]         wlevel_o,
    output logic [IW-1:0]         grant_id_o,
    output wr_state_e             state_o
);

    wr_state_e       state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [PW-1:0]   wbin_q, wbin_d;
    logic [PW-1:0]   wgray_q, wgray_d;
    logic [PW-1:0]   wlevel_q, wlevel_d;
    logic            wfull_q, wfull_d;
    logic            wafull_q, wafull_d;
    logic [PW-1:0]   rbin;

    logic [NREQ-1:0] arb_oh, grant_oh, ready, beat_acc;
    logic [IW-1:0]   arb_idx, grant;
    logic            push, push_last;

    fifo_wr_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i     (req_if.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    // While locked the grant stays on the packet owner even if it idles a cycle.
    always_comb begin
        grant     = (state_q == ST_LOCKED) ? gid_q : arb_idx;
        grant_oh  = (state_q == ST_LOCKED) ? (NREQ'(1) << gid_q) : arb_oh;
        ready     = grant_oh & ((state_q == ST_LOCKED) ? {NREQ{1'b1}} : req_if.req_valid);
        ready     = ready & {NREQ{~wfull_q & wrst_n}};
        beat_acc  = ready & req_if.req_valid;
        push      = |beat_acc;
        push_last = |(beat_acc & req_if.req_last);
        mem_wdata_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                mem_wdata_o = req_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        if (push) begin
            gid_d = grant;
            if (push_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
            end else begin
                state_d = ST_LOCKED;
            end
        end
    end

    // Full compares the next Gray pointer against the read pointer with its top two bits flipped.
    always_comb begin
        wbin_d   = wbin_q + PW'(push);
        wgray_d  = PW'(bin2gray(ptr_max_t'(wbin_d)));
        rbin     = PW'(gray2bin(ptr_max_t'(wq2_rptr_i)));
        wfull_d  = (wgray_d == {~wq2_rptr_i[PW-1:PW-2], wq2_rptr_i[PW-3:0]});
        wlevel_d = wbin_d - rbin;
        wafull_d = (wlevel_d >= PW'(AFULL_TH));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    assign req_if.req_ready = ready;
    assign mem_wen_o        = push;
    assign mem_waddr_o      = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_o           = wgray_q;
    assign wfull_o          = wfull_q;
    assign wafull_o         = wafull_q;
    assign wlevel_o         = wlevel_q;
    assign grant_id_o       = push ? grant : gid_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: per-requester beat sources, expected-write queue and a
// read-pointer model that predicts wptr/wlevel/wfull/wafull each cycle.
module tb_fifo_wr_sched;
    import fifo_wr_sched_pkg::*;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int NREQ = 4;
    localparam int PW   = AW + 1;
    localparam int IW   = 2;

    // clock / reset
    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    fifo_wr_sched_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) req_if ();

    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] wq2_rptr;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [PW-1:0] wptr, wlevel;
    logic          wfull, wafull;
    logic [IW-1:0] grant_id;
    wr_state_e     state;

    assign wq2_rptr = rptr_bin ^ (rptr_bin >> 1);

    fifo_wr_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NREQ), .AFULL_TH(12)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req_if      (req_if),
        .wq2_rptr_i  (wq2_rptr),
        .mem_wen_o   (mem_wen),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata),
        .wptr_o      (wptr),
        .wfull_o     (wfull),
        .wafull_o    (wafull),
        .wlevel_o    (wlevel),
        .grant_id_o  (grant_id),
        .state_o     (state)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW:0]   src_mem [NREQ][64];
    int            src_rd [NREQ];
    int            src_wr [NREQ];
    logic [NREQ-1:0] acc;
    logic [PW-1:0] cnt, exp_wptr, exp_lvl;
    logic          exp_full, exp_afull;
    int            wr_total;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int id, input int tag, input int n);
        return {8'(id), 8'(tag), 16'(n)};
    endfunction

    task automatic enq(input int id, input logic [DW-1:0] d, input logic last, input bit expect_it);
        src_mem[id][src_wr[id]] = {last, d};
        src_wr[id]++;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        acc = '0;
        exp_q.delete();
        req_if.req_valid = '0;
        req_if.req_last  = '0;
        req_if.req_data  = '0;
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_if.req_valid[i]         = 1'b1;
                req_if.req_last[i]          = src_mem[i][src_rd[i]][DW];
                req_if.req_data[i*DW +: DW] = src_mem[i][src_rd[i]][DW-1:0];
            end else begin
                req_if.req_valid[i]         = 1'b0;
                req_if.req_last[i]          = 1'b0;
                req_if.req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #2;
        wrst_n   = 1'b0;
        flush();
        rptr_bin = '0;
        repeat (2) @(posedge wclk);
        #3;
        wrst_n = 1'b1;
    endtask

    task automatic sync_mid();
        @(negedge wclk);
        #1;
    endtask

    task automatic set_rptr(input logic [PW-1:0] v);
        @(posedge wclk);
        #2;
        rptr_bin = v;
    endtask

    task automatic wait_acc(input int id, input int n, input int budget);
        int c = 0;
        while (src_rd[id] < n && c < budget) begin
            @(posedge wclk);
            #3;
            c++;
        end
        chk($sformatf("accept_wait_req%0d", id), 64'(src_rd[id] >= n), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge wclk);
            #3;
            c++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // driver: retire accepted beats just after each edge, then present the next ones
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) src_rd[i]++;
            end
            drive_srcs();
        end
    end

    // scoreboard / monitor on the falling edge
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin
                chk("rst_wen", 64'(mem_wen), 64'd0);
                chk("rst_ready", 64'(req_if.req_ready), 64'd0);
                chk("rst_wptr", 64'(wptr), 64'd0);
                chk("rst_wlevel", 64'(wlevel), 64'd0);
                chk("rst_wfull", 64'(wfull), 64'd0);
                cnt = '0;
                wr_total = 0;
            end else begin
                chk("wptr", 64'(wptr), 64'(exp_wptr));
                chk("wlevel", 64'(wlevel), 64'(exp_lvl));
                chk("wfull", 64'(wfull), 64'(exp_full));
                chk("wafull", 64'(wafull), 64'(exp_afull));
                chk("ready_onehot", 64'($countones(req_if.req_ready) > 1), 64'd0);
                if (mem_wen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wdata", 64'(mem_wdata), 64'(e));
                        chk("grant_id", 64'(grant_id), 64'(e[25:24]));
                    end
                    chk("waddr", 64'(mem_waddr), 64'(cnt[AW-1:0]));
                    cnt = cnt + 1'b1;
                    wr_total++;
                end
            end
            exp_wptr  = cnt ^ (cnt >> 1);
            exp_lvl   = cnt - rptr_bin;
            exp_full  = (exp_lvl == PW'(2**AW));
            exp_afull = (exp_lvl >= PW'(12));
            acc = req_if.req_valid & req_if.req_ready;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wrst_n   = 1'b0;
        rptr_bin = '0;
        cnt      = '0;
        wr_total = 0;
        flush();

        // 1: reset with a valid source, then fill to full from req0
        for (int n = 0; n < 17; n++) enq(0, beat(0, 1, n), 1'b1, n < 16);
        repeat (2) @(posedge wclk);
        #3;
        chk("t1_rst_wen", 64'(mem_wen), 64'd0);
        chk("t1_rst_ready", 64'(req_if.req_ready), 64'd0);
        chk("t1_rst_wptr", 64'(wptr), 64'd0);
        chk("t1_rst_wafull", 64'(wafull), 64'd0);
        chk("t1_rst_grant", 64'(grant_id), 64'd0);
        chk("t1_rst_state", 64'(state), 64'(ST_IDLE));
        wrst_n = 1'b1;
        wait_drain(40);
        sync_mid();
        sync_mid();
        chk("t1_full", 64'(wfull), 64'd1);
        chk("t1_wptr", 64'(wptr), 64'b11000);
        chk("t1_ready", 64'(req_if.req_ready), 64'd0);
        chk("t1_level", 64'(wlevel), 64'd16);

        // 2: all four valid with single-beat packets -> 0,1,2,3 rotation, a write every cycle
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int id = 0; id < NREQ; id++) enq(id, beat(id, 2, p), 1'b1, 1'b1);
        wait_drain(13);

        // 3: req1 packet keeps the grant although req2 is ahead in rotation
        do_reset();
        enq(1, beat(1, 3, 99), 1'b1, 1'b1);
        wait_acc(1, 1, 10);
        for (int n = 0; n < 4; n++) enq(1, beat(1, 3, n), n == 3, 1'b1);
        wait_acc(1, 2, 10);
        enq(2, beat(2, 3, 0), 1'b1, 1'b1);
        sync_mid();
        sync_mid();
        chk("t3_req2_ready", 64'(req_if.req_ready[2]), 64'd0);
        chk("t3_state", 64'(state), 64'(ST_LOCKED));
        wait_drain(20);

        // 4: fill to full mid-packet, release slots via the read pointer
        do_reset();
        for (int n = 0; n < 18; n++) enq(3, beat(3, 4, n), n == 17, 1'b1);
        wait_acc(3, 1, 10);
        enq(1, beat(1, 4, 0), 1'b1, 1'b1);
        wait_acc(3, 16, 40);
        sync_mid();
        sync_mid();
        chk("t4_full", 64'(wfull), 64'd1);
        chk("t4_ready", 64'(req_if.req_ready), 64'd0);
        chk("t4_locked", 64'(state), 64'(ST_LOCKED));
        set_rptr(PW'(1));
        wait_acc(3, 17, 10);
        set_rptr(PW'(2));
        wait_acc(3, 18, 10);
        set_rptr(PW'(8));
        wait_drain(10);

        // 5: 40 pushes with the reader trailing, across pointer wrap
        do_reset();
        for (int n = 0; n < 40; n++) enq(0, beat(0, 5, n), 1'b1, 1'b1);
        begin
            int c = 0;
            while (exp_q.size() != 0 && c < 100) begin
                @(posedge wclk);
                #2;
                if (wr_total == 20) chk("t5_level", 64'(wlevel), 64'd3);
                rptr_bin = (wr_total >= 2) ? PW'(wr_total - 2) : '0;
                c++;
            end
            chk("t5_drain", 64'(exp_q.size()), 64'd0);
        end

        // 6: reset while locked mid-packet
        do_reset();
        for (int n = 0; n < 5; n++) enq(2, beat(2, 6, n), n == 4, 1'b1);
        wait_acc(2, 2, 10);
        @(posedge wclk);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("t6_async_wen", 64'(mem_wen), 64'd0);
        chk("t6_async_ready", 64'(req_if.req_ready), 64'd0);
        chk("t6_async_wptr", 64'(wptr), 64'd0);
        chk("t6_async_level", 64'(wlevel), 64'd0);
        chk("t6_async_state", 64'(state), 64'(ST_IDLE));
        chk("t6_async_grant", 64'(grant_id), 64'd0);
        flush();
        rptr_bin = '0;
        repeat (2) @(posedge wclk);
        #3;
        wrst_n = 1'b1;
        sync_mid();
        chk("t6_state_idle", 64'(state), 64'(ST_IDLE));
        enq(1, beat(1, 6, 0), 1'b1, 1'b1);
        enq(3, beat(3, 6, 0), 1'b1, 1'b1);
        wait_drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
